// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
//   Shared definitions for the oscillator bank:
//   - waveform mode encoding (OFF/SAW/SQUARE/TRI)
//   - configuration register offsets and control-register bit positions
//   - clog2 helper used to size the slot counter, channel index and mixer
//     accumulator
// -----------------------------------------------------------------------------
package synth_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_SAW    = 2'd1,
      MODE_SQUARE = 2'd2,
      MODE_TRI    = 2'd3
   } mode_e;

   // Register offsets within a channel (cfg_addr[1:0])
   localparam logic [1:0] REG_PERIOD_LO = 2'd0;
   localparam logic [1:0] REG_PERIOD_HI = 2'd1;
   localparam logic [1:0] REG_OCT       = 2'd2;
   localparam logic [1:0] REG_CTRL      = 2'd3;

   // Control register fields
   localparam int CTRL_MODE_LSB      = 0;
   localparam int CTRL_ATTEN_LSB     = 2;
   localparam int CTRL_PHASE_RST_BIT = 4;

   // Ceiling log2; clog2(1) = 0
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) result++;
      return result;
   endfunction

   // Mixer accumulator width: wide enough that NUM_OSCS full-scale
   // WAVE_BITS samples can never overflow, and never narrower than WAVE_BITS+1.
   function automatic int acc_width(input int wave_bits, input int num_oscs);
      return (clog2(num_oscs) < 1) ? wave_bits + 1 : wave_bits + clog2(num_oscs);
   endfunction

endpackage

// File: rtl/synth_wave_shaper.sv
// -----------------------------------------------------------------------------
// synth_wave_shaper
//   Combinational waveform shaping of one channel's phase accumulator.
//   Ports:
//     wave   in  WAVE_BITS  phase accumulator value (unsigned ramp)
//     mode   in  mode_e     OFF / SAW / SQUARE / TRI
//     atten  in  2          arithmetic right shift applied after shaping
//     shaped out WAVE_BITS  signed shaped, attenuated sample
// -----------------------------------------------------------------------------
module synth_wave_shaper
   import synth_pkg::*;
#(
   parameter int WAVE_BITS = 4
) (
   input  logic [WAVE_BITS-1:0]        wave,
   input  mode_e                       mode,
   input  logic [1:0]                  atten,
   output logic signed [WAVE_BITS-1:0] shaped
);

   // Bit pattern of -2^(W-1); its complement is +2^(W-1)-1
   localparam logic [WAVE_BITS-1:0] HALF = {1'b1, {(WAVE_BITS-1){1'b0}}};

   logic [WAVE_BITS-2:0]        tri_t;
   logic signed [WAVE_BITS-1:0] raw;

   // NOTE: every signal written here gets a value before any branch, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      raw   = '0;
      tri_t = wave[WAVE_BITS-1] ? ~wave[WAVE_BITS-2:0] : wave[WAVE_BITS-2:0];
      case (mode)
         MODE_OFF:    raw = '0;
         // w - 2^(W-1) is the ramp with its MSB flipped
         MODE_SAW:    raw = wave ^ HALF;
         MODE_SQUARE: raw = wave[WAVE_BITS-1] ? HALF : ~HALF;
         // 2t - 2^(W-1): double the folded ramp, then flip the MSB
         MODE_TRI:    raw = {tri_t, 1'b0} ^ HALF;
         default:     raw = '0;
      endcase
      shaped = raw >>> atten;
   end

endmodule

// File: rtl/synth_osc_bank.sv
// -----------------------------------------------------------------------------
// synth_osc_bank
//   Time-multiplexed bank of NUM_OSCS oscillators sharing one step datapath,
//   one octave divider and one mixer accumulator. A frame is NUM_OSCS+1
//   cycles: slot i < NUM_OSCS services channel i, the last slot publishes the
//   mixed sample.
//   Ports:
//     clk          in   1         clock
//     rst_n        in   1         asynchronous active-low reset
//     cfg_addr     in   5         {channel[2:0], reg[1:0]}
//     cfg_data     in   8         write data
//     cfg_we       in   1         write strobe
//     sample_out   out  OUT_BITS  mixed sample, offset binary
//     sample_valid out  1         pulse when sample_out updates
//     frame_start  out  1         high during slot 0
// -----------------------------------------------------------------------------
module synth_osc_bank
   import synth_pkg::*;
#(
   parameter int NUM_OSCS     = 4,
   parameter int OCT_BITS     = 4,
   parameter int PERIOD_BITS  = 10,
   parameter int DIVIDER_BITS = 18,
   parameter int WAVE_BITS    = 4,
   parameter int OUT_BITS     = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [4:0]          cfg_addr,
   input  logic [7:0]          cfg_data,
   input  logic                cfg_we,
   output logic [OUT_BITS-1:0] sample_out,
   output logic                sample_valid,
   output logic                frame_start
);

   localparam int ACC_BITS  = acc_width(WAVE_BITS, NUM_OSCS);
   localparam int SLOT_BITS = clog2(NUM_OSCS + 1);
   localparam int CH_BITS   = (clog2(NUM_OSCS) < 1) ? 1 : clog2(NUM_OSCS);
   localparam logic [OUT_BITS-1:0] OUT_MID = {1'b1, {(OUT_BITS-1){1'b0}}};

   // Per-channel configuration
   logic [PERIOD_BITS-1:0] period_q  [NUM_OSCS];
   logic [OCT_BITS-1:0]    oct_q     [NUM_OSCS];
   mode_e                  mode_q    [NUM_OSCS];
   logic [1:0]             atten_q   [NUM_OSCS];
   // Per-channel running state
   logic [PERIOD_BITS-1:0] counter_q [NUM_OSCS];
   logic [WAVE_BITS-1:0]   wave_q    [NUM_OSCS];

   logic [SLOT_BITS-1:0]       slot_q;
   logic [DIVIDER_BITS-1:0]    divider_q;
   logic signed [ACC_BITS-1:0] acc_q;

   // ---------------------------------------------------------------- config
   logic [2:0]         wr_chan;
   logic [CH_BITS-1:0] wr_ch;
   logic [1:0]         wr_reg;
   logic               wr_hit;
   logic               phase_rst;

   assign wr_chan   = cfg_addr[4:2];
   assign wr_ch     = wr_chan[CH_BITS-1:0];
   assign wr_reg    = cfg_addr[1:0];
   assign wr_hit    = cfg_we && (int'(wr_chan) < NUM_OSCS);
   assign phase_rst = wr_hit && (wr_reg == REG_CTRL) && cfg_data[CTRL_PHASE_RST_BIT];

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values; this is what makes a same-cycle update see old config.
   // NOTE: these arrays are plain flops, not RAM, so they take the async
   // reset like any other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_OSCS; i++) begin
            period_q[i] <= '0;
            oct_q[i]    <= '0;
            mode_q[i]   <= MODE_OFF;
            atten_q[i]  <= '0;
         end
      end else if (wr_hit) begin
         case (wr_reg)
            REG_PERIOD_LO: period_q[wr_ch][7:0] <= cfg_data;
            REG_PERIOD_HI: period_q[wr_ch][PERIOD_BITS-1:8] <= cfg_data[PERIOD_BITS-9:0];
            REG_OCT:       oct_q[wr_ch] <= cfg_data[OCT_BITS-1:0];
            REG_CTRL: begin
               mode_q[wr_ch]  <= mode_e'(cfg_data[CTRL_MODE_LSB +: 2]);
               atten_q[wr_ch] <= cfg_data[CTRL_ATTEN_LSB +: 2];
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------- step datapath
   logic                       slot_is_mix;
   logic [CH_BITS-1:0]         ch;
   logic [DIVIDER_BITS:0]      oct_en;
   logic                       step_en;
   logic [PERIOD_BITS-1:0]     next_counter;
   logic [WAVE_BITS-1:0]       next_wave;
   logic signed [WAVE_BITS-1:0] shaped;
   logic signed [ACC_BITS-1:0] acc_next;

   assign slot_is_mix = (slot_q == SLOT_BITS'(NUM_OSCS));
   assign ch          = slot_q[CH_BITS-1:0];
   assign frame_start = (slot_q == '0);

   // Divider bit k-1 rose on the last increment exactly when it is the lowest
   // set bit of the current divider value; d & ~(d-1) isolates that bit.
   assign oct_en = {divider_q & ~(divider_q - DIVIDER_BITS'(1)), 1'b1};

   always_comb begin
      step_en      = 1'b0;
      next_counter = counter_q[ch];
      next_wave    = wave_q[ch];
      // Octaves beyond the divider never match, so such channels never step
      for (int k = 0; k <= DIVIDER_BITS; k++) begin
         if (int'(oct_q[ch]) == k) step_en = oct_en[k];
      end
      if (slot_is_mix) step_en = 1'b0;
      if (counter_q[ch] == '0) begin
         // Period 0 wraps to all-ones, i.e. a period of 2^PERIOD_BITS
         next_counter = period_q[ch] - PERIOD_BITS'(1);
         next_wave    = wave_q[ch] + WAVE_BITS'(1);
      end else begin
         next_counter = counter_q[ch] - PERIOD_BITS'(1);
      end
   end

   synth_wave_shaper #(
      .WAVE_BITS (WAVE_BITS)
   ) u_shaper (
      .wave   (wave_q[ch]),
      .mode   (mode_q[ch]),
      .atten  (atten_q[ch]),
      .shaped (shaped)
   );

   assign acc_next = acc_q + {{(ACC_BITS-WAVE_BITS){shaped[WAVE_BITS-1]}}, shaped};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_OSCS; i++) begin
            counter_q[i] <= '0;
            wave_q[i]    <= '0;
         end
      end else begin
         if (step_en) begin
            counter_q[ch] <= next_counter;
            wave_q[ch]    <= next_wave;
         end
         // Issued after the step so a phase reset overrides a same-cycle
         // update of the same channel.
         if (phase_rst) begin
            counter_q[wr_ch] <= '0;
            wave_q[wr_ch]    <= '0;
         end
      end
   end

   // ----------------------------------------------------------------- mixer
   logic [OUT_BITS-1:0] scaled;

   if (ACC_BITS >= OUT_BITS) begin : g_scale_down
      // acc >>> (ACC_BITS-OUT_BITS) truncated to OUT_BITS is its top bits
      assign scaled = acc_q[ACC_BITS-1 -: OUT_BITS];
   end else begin : g_scale_up
      assign scaled = {acc_q, {(OUT_BITS-ACC_BITS){1'b0}}};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q       <= '0;
         divider_q    <= '0;
         acc_q        <= '0;
         sample_out   <= OUT_MID;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (slot_is_mix) begin
            slot_q       <= '0;
            divider_q    <= divider_q + DIVIDER_BITS'(1);
            acc_q        <= '0;
            // Two's complement to offset binary
            sample_out   <= scaled ^ OUT_MID;
            sample_valid <= 1'b1;
         end else begin
            slot_q <= slot_q + SLOT_BITS'(1);
            acc_q  <= acc_next;
         end
      end
   end

endmodule

// File: tb/tb_synth_osc_bank.sv
// -----------------------------------------------------------------------------
// tb_synth_osc_bank
//   Frame-locked directed stimulus for synth_osc_bank (default parameters).
//   The driver pushes the hand-derived expected sample of every frame it runs;
//   a monitor pops and compares each time sample_valid is seen.
// -----------------------------------------------------------------------------
module tb_synth_osc_bank;

   localparam int NUM_OSCS = 4;

   logic       clk;
   logic       rst_n;
   logic [4:0] cfg_addr;
   logic [7:0] cfg_data;
   logic       cfg_we;
   logic [7:0] sample_out;
   logic       sample_valid;
   logic       frame_start;

   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;
   int         checks;
   int         errors;
   int         frame_no;

   synth_osc_bank dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .cfg_we       (cfg_we),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .frame_start  (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && sample_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sample_unexpected: got %02h, expected no sample", sample_out);
         end else begin
            mon_exp = exp_q.pop_front();
            check("sample", {24'd0, sample_out}, {24'd0, mon_exp});
         end
      end
   end

   // Called at the negedge of a slot-0 cycle; leaves at the next slot-0 negedge.
   // Optionally issues one write during slot wslot (-1: none).
   task automatic run_frame(input logic [7:0] exp, input int wslot,
                            input logic [4:0] a, input logic [7:0] d);
      check("frame_start_slot0", frame_start, 1);
      exp_q.push_back(exp);
      for (int s = 0; s <= NUM_OSCS; s++) begin
         if (s > 0) begin
            check("frame_start_mid", frame_start, 0);
            check("valid_mid", sample_valid, 0);
         end
         cfg_we   = (s == wslot);
         cfg_addr = a;
         cfg_data = d;
         @(negedge clk);
      end
      cfg_we = 1'b0;
      frame_no++;
   endtask

   // Called right after rst_n rises at a negedge: first sample 5 cycles later
   task automatic after_release();
      frame_no = 0;
      exp_q.push_back(8'h80);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         check("first_valid_latency", sample_valid, (i == 5) ? 1 : 0);
      end
      frame_no = 1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 100us");
      $fatal(1);
   end

   initial begin
      logic [7:0] e;
      int         w;
      checks   = 0;
      errors   = 0;
      frame_no = 0;
      rst_n    = 1'b0;
      cfg_we   = 1'b0;
      cfg_addr = '0;
      cfg_data = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_sample_out", sample_out, 8'h80);
      check("reset_valid", sample_valid, 0);
      check("reset_frame_start", frame_start, 1);
      rst_n = 1'b1;
      after_release();

      // Idle: mid-scale every frame
      repeat (2) run_frame(8'h80, -1, 5'h00, 8'h00);

      // ch0 saw, period 1, oct 0: sample = 0x60 + 4*wave, wave steps each frame
      run_frame(8'h80, 1, 5'h00, 8'h01);
      run_frame(8'h80, 1, 5'h03, 8'h11);
      for (int i = 0; i <= 18; i++) begin
         e = 8'h60 + 8'(4 * (i % 16));
         run_frame(e, (i == 18) ? 1 : -1, 5'h03, 8'h00);   // last frame turns ch0 off
      end

      // ch1 square, period 2, oct 1. Phase reset lands in an even frame P; the
      // octave-1 tick is in odd frames, so frame P+j shows wave (j+2)/4.
      run_frame(8'h80, 1, 5'h04, 8'h02);
      run_frame(8'h80, 1, 5'h06, 8'h01);
      if (frame_no % 2 != 0) run_frame(8'h80, -1, 5'h00, 8'h00);
      run_frame(8'h80, 3, 5'h07, 8'h12);
      for (int j = 1; j <= 65; j++) begin
         w = ((j + 2) / 4) % 16;
         e = (w >= 8) ? 8'h60 : 8'h9C;
         run_frame(e, (j == 65) ? 3 : -1, 5'h07, 8'h00);  // last frame turns ch1 off
      end

      // ch0 saw atten 2 from wave 0; oct 15 from frame 14 on holds wave at 15
      run_frame(8'h80, 1, 5'h03, 8'h19);
      for (int k = 0; k <= 20; k++) begin
         e = (k < 15) ? 8'h78 + 8'(4 * (k / 4)) : 8'h84;
         run_frame(e, (k == 14) ? 1 : -1, 5'h02, 8'h0F);
      end

      // Writes to channels 5 and 4 are ignored
      run_frame(8'h84, 1, 5'h17, 8'h11);
      run_frame(8'h84, 1, 5'h13, 8'h11);
      run_frame(8'h84, -1, 5'h00, 8'h00);

      // Re-enable stepping (wave 15 -> 0), then a phase reset in ch0's own slot
      // must beat the simultaneous 0 -> 1 step.
      run_frame(8'h84, 1, 5'h02, 8'h00);
      run_frame(8'h84, -1, 5'h00, 8'h00);
      run_frame(8'h78, 0, 5'h03, 8'h11);
      run_frame(8'h60, -1, 5'h00, 8'h00);
      run_frame(8'h64, -1, 5'h00, 8'h00);
      run_frame(8'h68, -1, 5'h00, 8'h00);

      // Async reset in slot 2
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_sample", sample_out, 8'h68);
      check("pre_reset_frame_start", frame_start, 0);
      rst_n = 1'b0;
      #1;
      check("midreset_sample_out", sample_out, 8'h80);
      check("midreset_valid", sample_valid, 0);
      check("midreset_frame_start", frame_start, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      after_release();
      repeat (2) run_frame(8'h80, -1, 5'h00, 8'h00);

      @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
